// File: rtl/count_chain.sv
// count_chain: cascade of NUM_STAGE modulo up/down counters with per-stage
// runtime modulus, parallel load, per-stage carry outputs and a registered
// chain-wrap pulse. Stage 0 is least significant; higher stages step on the
// carry/borrow of the stage below within the same clock edge.
//
// Optional feature (macro COUNT_CHAIN_STICKY_EN): sticky overflow/underflow
// flags ovf_o/unf_o with a clr_flags input. Without the macro those ports and
// registers do not exist.
module count_chain #(
  parameter int NUM_STAGE   = 3,
  parameter int NUM_BIT     = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         inc,
  input  logic                         dec,
  input  logic                         load,
  input  logic [NUM_STAGE*NUM_BIT-1:0] load_value,
  input  logic [NUM_STAGE*NUM_BIT-1:0] max_count,
  output logic [NUM_STAGE*NUM_BIT-1:0] count_o,
  output logic [NUM_STAGE-1:0]         carry_o,
`ifdef COUNT_CHAIN_STICKY_EN
  input  logic                         clr_flags,
  output logic                         ovf_o,
  output logic                         unf_o,
`endif
  output logic                         wrap_o
);

  localparam logic [NUM_BIT-1:0] RST_V = RESET_VALUE[NUM_BIT-1:0];

  logic                         step;
  logic                         dir_up;
  logic [NUM_STAGE*NUM_BIT-1:0] count_nxt;

  assign step   = en & (inc ^ dec);
  assign dir_up = inc;

  // Ripple the step through the stages: each stage steps only when every
  // stage below it is stepping and at its terminal value.
  always_comb begin
    logic               ripple;
    logic               term;
    logic [NUM_BIT-1:0] c;
    logic [NUM_BIT-1:0] m;
    count_nxt = count_o;
    carry_o   = '0;
    ripple    = step;
    term      = 1'b0;
    c         = '0;
    m         = '0;
    for (int k = 0; k < NUM_STAGE; k++) begin
      c = count_o[k*NUM_BIT +: NUM_BIT];
      m = max_count[k*NUM_BIT +: NUM_BIT];
      // Down-count treats values above max as terminal so they recover to max.
      if (dir_up) term = (c >= m);
      else        term = (c == RST_V) || (c > m);
      if (ripple) begin
        if (dir_up) count_nxt[k*NUM_BIT +: NUM_BIT] = term ? RST_V : c + NUM_BIT'(1);
        else        count_nxt[k*NUM_BIT +: NUM_BIT] = term ? m : c - NUM_BIT'(1);
      end
      carry_o[k] = ripple & term & ~load;
      ripple     = ripple & term;
    end
  end

  // Stage registers and wrap pulse; load overrides stepping regardless of en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_o <= {NUM_STAGE{RST_V}};
      wrap_o  <= 1'b0;
    end else begin
      if (load) count_o <= load_value;
      else      count_o <= count_nxt;
      wrap_o <= carry_o[NUM_STAGE-1];
    end
  end

`ifdef COUNT_CHAIN_STICKY_EN
  // Sticky wrap flags; a new wrap on the same edge beats clr_flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (carry_o[NUM_STAGE-1] && dir_up) ovf_o <= 1'b1;
      else if (clr_flags)                 ovf_o <= 1'b0;
      if (carry_o[NUM_STAGE-1] && !dir_up) unf_o <= 1'b1;
      else if (clr_flags)                  unf_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_count_chain.sv
// Testbench for count_chain: directed steps from the test plan followed by a
// randomized run, all checked against a per-stage arithmetic reference model.
module tb_count_chain;
  localparam int NS = 3;
  localparam int NB = 8;
  localparam int RV = 0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic              inc = 1'b0;
  logic              dec = 1'b0;
  logic              load = 1'b0;
  logic [NS*NB-1:0]  load_value = '0;
  logic [NS*NB-1:0]  max_count;
  logic [NS*NB-1:0]  count_o;
  logic [NS-1:0]     carry_o;
  logic              wrap_o;
`ifdef COUNT_CHAIN_STICKY_EN
  logic              clr_flags = 1'b0;
  logic              ovf_o;
  logic              unf_o;
  bit                m_ovf = 0;
  bit                m_unf = 0;
`endif

  int checks = 0;
  int errors = 0;
  int mc[NS];
  bit m_wrap = 0;

  always #5 clk = ~clk;

  count_chain #(.NUM_STAGE(NS), .NUM_BIT(NB), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .dec(dec),
    .load(load), .load_value(load_value), .max_count(max_count),
    .count_o(count_o), .carry_o(carry_o),
`ifdef COUNT_CHAIN_STICKY_EN
    .clr_flags(clr_flags), .ovf_o(ovf_o), .unf_o(unf_o),
`endif
    .wrap_o(wrap_o)
  );

  function automatic logic [NS*NB-1:0] pack3(int s2, int s1, int s0);
    logic [NS*NB-1:0] v;
    v = '0;
    v[0*NB +: NB] = s0[NB-1:0];
    v[1*NB +: NB] = s1[NB-1:0];
    v[2*NB +: NB] = s2[NB-1:0];
    return v;
  endfunction

  function automatic int fld(logic [NS*NB-1:0] v, int k);
    return int'(v[k*NB +: NB]);
  endfunction

  function automatic bit is_term(int c, int m, bit up);
    if (up) return c >= m;
    return (c == RV) || (c > m);
  endfunction

  function automatic logic [NS*NB-1:0] model_count();
    logic [NS*NB-1:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) v[k*NB +: NB] = mc[k][NB-1:0];
    return v;
  endfunction

  function automatic logic [NS-1:0] model_carry();
    logic [NS-1:0] cy;
    bit s;
    cy = '0;
    if (load) return cy;
    s = en && (inc != dec);
    for (int k = 0; k < NS; k++) begin
      s = s && is_term(mc[k], fld(max_count, k), inc);
      cy[k] = s;
    end
    return cy;
  endfunction

  task automatic model_edge();
    logic [NS-1:0] cy;
    bit s;
    bit t;
    cy = model_carry();
    if (load) begin
      for (int k = 0; k < NS; k++) mc[k] = fld(load_value, k);
    end else begin
      s = en && (inc != dec);
      for (int k = 0; k < NS; k++) begin
        if (s) begin
          t = is_term(mc[k], fld(max_count, k), inc);
          if (inc) mc[k] = t ? RV : mc[k] + 1;
          else     mc[k] = t ? fld(max_count, k) : mc[k] - 1;
          s = t;
        end
      end
    end
    m_wrap = cy[NS-1];
`ifdef COUNT_CHAIN_STICKY_EN
    if (cy[NS-1] && inc) m_ovf = 1;
    else if (clr_flags)  m_ovf = 0;
    if (cy[NS-1] && !inc) m_unf = 1;
    else if (clr_flags)   m_unf = 0;
`endif
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) mc[k] = RV;
    m_wrap = 0;
`ifdef COUNT_CHAIN_STICKY_EN
    m_ovf = 0;
    m_unf = 0;
`endif
  endtask

  // One clock: check carry before the edge, then state after it.
  task automatic tick();
    #1;
    check("carry", 64'(carry_o), 64'(model_carry()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("count", 64'(count_o), 64'(model_count()));
    check("wrap", 64'(wrap_o), 64'(m_wrap));
`ifdef COUNT_CHAIN_STICKY_EN
    check("ovf", 64'(ovf_o), 64'(m_ovf));
    check("unf", 64'(unf_o), 64'(m_unf));
`endif
  endtask

  task automatic drive(bit e, bit i, bit d, bit l);
    en = e; inc = i; dec = d; load = l;
  endtask

  initial begin
    max_count = pack3(23, 59, 59);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_count", 64'(count_o), 64'(pack3(0, 0, 0)));
    check("rst_wrap", 64'(wrap_o), 64'd0);
    reset_n = 1'b1;

    // up ripple through all stages
    load_value = pack3(23, 59, 58);
    drive(0, 0, 0, 1); tick();
    drive(1, 1, 0, 0); tick();
    check("up_first", 64'(count_o), 64'(pack3(23, 59, 59)));
    #1 check("up_carry111", 64'(carry_o), 64'b111);
    tick();
    check("up_wrap_cnt", 64'(count_o), 64'(pack3(0, 0, 0)));
    check("up_wrap_pulse", 64'(wrap_o), 64'd1);
    drive(0, 0, 0, 0); tick();
    check("wrap_one_cycle", 64'(wrap_o), 64'd0);

    // down borrow
    load_value = pack3(1, 0, 0);
    drive(0, 0, 0, 1); tick();
    drive(1, 0, 1, 0);
    #1 check("dn_carry011", 64'(carry_o), 64'b011);
    tick();
    check("dn_borrow", 64'(count_o), 64'(pack3(0, 59, 59)));
    check("dn_nowrap", 64'(wrap_o), 64'd0);

    // holds
    drive(1, 1, 1, 0);
    repeat (5) tick();
    check("hold_both", 64'(count_o), 64'(pack3(0, 59, 59)));
    drive(0, 1, 0, 0);
    repeat (2) tick();
    check("hold_en0", 64'(count_o), 64'(pack3(0, 59, 59)));
    load_value = pack3(5, 6, 7);
    drive(0, 0, 0, 1); tick();
    check("load_en0", 64'(count_o), 64'(pack3(5, 6, 7)));

    // out-of-range recovery
    load_value = pack3(5, 6, 70);
    drive(0, 0, 0, 1); tick();
    drive(1, 1, 0, 0); tick();
    check("oor_up", 64'(count_o), 64'(pack3(5, 7, 0)));
    drive(0, 0, 0, 1); tick();
    drive(1, 0, 1, 0); tick();
    check("oor_dn", 64'(count_o), 64'(pack3(5, 5, 59)));

    // asynchronous reset while wrap_o is high
    load_value = pack3(23, 59, 59);
    drive(0, 0, 0, 1); tick();
    drive(1, 1, 0, 0); tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_cnt", 64'(count_o), 64'(pack3(0, 0, 0)));
    check("async_rst_wrap", 64'(wrap_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef COUNT_CHAIN_STICKY_EN
    load_value = pack3(23, 59, 59);
    drive(0, 0, 0, 1); tick();
    drive(1, 1, 0, 0); tick();
    check("ovf_set", 64'(ovf_o), 64'd1);
    repeat (3) tick();
    check("ovf_sticky", 64'(ovf_o), 64'd1);
    drive(0, 0, 0, 1); tick();
    drive(1, 1, 0, 0); clr_flags = 1'b1; tick();
    check("ovf_set_wins", 64'(ovf_o), 64'd1);
    drive(0, 0, 0, 0); tick();
    check("ovf_clr", 64'(ovf_o), 64'd0);
    clr_flags = 1'b0;
    load_value = pack3(0, 0, 0);
    drive(0, 0, 0, 1); tick();
    drive(1, 0, 1, 0); tick();
    check("unf_cnt", 64'(count_o), 64'(pack3(23, 59, 59)));
    check("unf_set", 64'(unf_o), 64'd1);
`endif

    // randomized run with small moduli so wraps are frequent
    max_count = pack3(3, 2, 4);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        max_count = pack3($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5));
      load_value = pack3($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
`ifdef COUNT_CHAIN_STICKY_EN
      clr_flags = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
